// File: rtl/mod23_frame_accum.sv
// Folds per-word mod-23 remainders, most-significant word first, into the residue of a
// multi-word operand: acc = (acc*9 + r) mod 23. Emits one registered result per frame.
`timescale 1ns/1ps
module mod23_frame_accum #(
  parameter int REM_W     = 5,
  parameter int MOD       = 23,
  parameter int WORD_MOD  = 9,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [REM_W-1:0] s_rem_i,
  input  logic             s_first_i,
  input  logic             s_last_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [REM_W-1:0] m_res_o,
  output logic [CNT_W-1:0] m_words_o,
  output logic             m_err_o,
  output logic             proto_err_o
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

  state_e           state_q, state_d;
  logic [REM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             proto_q, proto_d;
  logic             alive_q;
  logic [REM_W-1:0] m_res_q;
  logic [CNT_W-1:0] m_words_q;
  logic             m_err_q;

  logic             s_fire, m_fire, bad_rem, cnt_full;
  logic [REM_W-1:0] r_red, acc_fold;
  logic [7:0]       fold_x;

  // alive_q keeps s_ready low until the first edge after reset release
  assign s_ready_o   = alive_q && (state_q != HOLD);
  assign m_valid_o   = (state_q == HOLD);
  assign s_fire      = s_valid_i && s_ready_o;
  assign m_fire      = m_valid_o && m_ready_i;
  assign m_res_o     = m_res_q;
  assign m_words_o   = m_words_q;
  assign m_err_o     = m_err_q;
  assign proto_err_o = proto_q;

  assign bad_rem  = (s_rem_i >= REM_W'(MOD));
  assign r_red    = bad_rem ? (s_rem_i - REM_W'(MOD)) : s_rem_i;
  assign cnt_full = (cnt_q == CNT_W'(MAX_WORDS));
  assign fold_x   = 8'(acc_q) * 8'(WORD_MOD) + 8'(r_red);
  assign acc_fold = REM_W'(fold_x % 8'(MOD));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    proto_d = 1'b0;
    case (state_q)
      IDLE, ACC: begin
        if (s_fire) begin
          if (s_first_i) begin
            // a first word always opens a fresh frame, abandoning any partial one
            proto_d = (state_q == ACC);
            acc_d   = r_red;
            cnt_d   = CNT_W'(1);
            err_d   = bad_rem;
            state_d = s_last_i ? HOLD : ACC;
          end else if (state_q == ACC) begin
            acc_d   = acc_fold;
            cnt_d   = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
            err_d   = err_q | bad_rem | cnt_full;
            state_d = s_last_i ? HOLD : ACC;
          end else begin
            proto_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (m_fire) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      proto_q   <= 1'b0;
      alive_q   <= 1'b0;
      m_res_q   <= '0;
      m_words_q <= '0;
      m_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      proto_q <= proto_d;
      alive_q <= 1'b1;
      // result registers load on HOLD entry and keep their value after the handshake
      if (state_d == HOLD && state_q != HOLD) begin
        m_res_q   <= acc_d;
        m_words_q <= cnt_d;
        m_err_q   <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_mod23_frame_accum.sv
// Random and directed frames against a whole-operand residue model (sum of r_i*65536^k mod 23).
`timescale 1ns/1ps
module tb_mod23_frame_accum;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid_i = 1'b0, s_ready_o;
  logic [4:0] s_rem_i = '0;
  logic       s_first_i = 1'b0, s_last_i = 1'b0;
  logic       m_valid_o, m_ready_i = 1'b0;
  logic [4:0] m_res_o;
  logic [4:0] m_words_o;
  logic       m_err_o, proto_err_o;

  mod23_frame_accum dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_rem_i(s_rem_i),
    .s_first_i(s_first_i), .s_last_i(s_last_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_res_o(m_res_o), .m_words_o(m_words_o), .m_err_o(m_err_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int q[$];
  int fw[$];
  bit in_frame = 1'b0;
  int exp_res = 0, exp_words = 0, exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Residue of the whole operand, treating each word as its true 16-bit weight.
  task automatic model_result();
    longint acc = 0;
    int bad = 0;
    foreach (q[i]) begin
      int r = q[i];
      if (r >= 23) begin r = r - 23; bad = 1; end
      acc = (acc * 65536 + r) % 23;
    end
    exp_res   = int'(acc);
    exp_words = (q.size() > 16) ? 16 : q.size();
    exp_err   = (bad != 0 || q.size() > 16) ? 1 : 0;
  endtask

  task automatic send(input int r, input bit f, input bit l);
    int n = 0;
    bit exp_proto;
    @(negedge clk);
    s_valid_i = 1'b1; s_rem_i = r[4:0]; s_first_i = f; s_last_i = l;
    while (!s_ready_o && n < 20) begin @(negedge clk); n++; end
    if (!s_ready_o) begin
      chk("s_ready_timeout", 32'(s_ready_o), 32'd1);
      s_valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_valid_i = 1'b0;
    exp_proto = (f && in_frame) || (!f && !in_frame);
    if (f) begin q.delete(); in_frame = 1'b1; end
    if (in_frame) q.push_back(r);
    chk("proto_err", 32'(proto_err_o), 32'(exp_proto));
    if (in_frame && l) begin
      model_result();
      in_frame = 1'b0;
      chk("m_valid_rise", 32'(m_valid_o), 32'd1);
      chk("m_res", 32'(m_res_o), exp_res);
      chk("m_words", 32'(m_words_o), exp_words);
      chk("m_err", 32'(m_err_o), exp_err);
    end else begin
      chk("m_valid_low", 32'(m_valid_o), 32'd0);
    end
  endtask

  task automatic collect(input int stall);
    repeat (stall) begin
      @(negedge clk); m_ready_i = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", 32'(m_valid_o), 32'd1);
      chk("hold_res", 32'(m_res_o), exp_res);
      chk("hold_words", 32'(m_words_o), exp_words);
      chk("hold_err", 32'(m_err_o), exp_err);
      chk("hold_s_ready", 32'(s_ready_o), 32'd0);
    end
    @(negedge clk); m_ready_i = 1'b1;
    @(posedge clk); #1;
    m_ready_i = 1'b0;
    chk("post_valid", 32'(m_valid_o), 32'd0);
    chk("post_s_ready", 32'(s_ready_o), 32'd1);
    chk("post_res_held", 32'(m_res_o), exp_res);
  endtask

  task automatic run_frame(input int stall);
    for (int i = 0; i < fw.size(); i++)
      send(fw[i], i == 0, i == fw.size() - 1);
    collect(stall);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_s_ready", 32'(s_ready_o), 32'd0);
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("rst_m_res", 32'(m_res_o), 32'd0);
    chk("rst_m_words", 32'(m_words_o), 32'd0);
    chk("rst_m_err", 32'(m_err_o), 32'd0);
    chk("rst_proto", 32'(proto_err_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_s_ready", 32'(s_ready_o), 32'd1);

    fw.delete(); fw.push_back(7); run_frame(0);
    fw.delete(); fw.push_back(1); fw.push_back(0); run_frame(0);
    fw.delete(); fw.push_back(1); fw.push_back(0); fw.push_back(0); run_frame(1);
    fw.delete(); fw.push_back(22); fw.push_back(22); run_frame(0);
    fw.delete(); fw.push_back(25); run_frame(0);
    fw.delete(); fw.push_back(3); run_frame(0);
    fw.delete(); for (int i = 0; i < 17; i++) fw.push_back(0); run_frame(0);

    // stray non-first word while idle: single-cycle pulse, no result
    send(9, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("proto_one_cycle", 32'(proto_err_o), 32'd0);
    chk("stray_no_result", 32'(m_valid_o), 32'd0);

    send(5, 1'b1, 1'b0);
    send(4, 1'b1, 1'b1);
    collect(0);

    fw.delete(); fw.push_back(11); fw.push_back(17); run_frame(3);

    // reset in the middle of a frame
    send(2, 1'b1, 1'b0);
    send(3, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    in_frame = 1'b0;
    chk("mid_rst_s_ready", 32'(s_ready_o), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("mid_rst_m_res", 32'(m_res_o), 32'd0);
    chk("mid_rst_m_words", 32'(m_words_o), 32'd0);
    chk("mid_rst_m_err", 32'(m_err_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_s_ready", 32'(s_ready_o), 32'd1);
    fw.delete(); fw.push_back(6); run_frame(0);

    for (int k = 0; k < 40; k++) begin
      int n = $urandom_range(1, 18);
      if ($urandom_range(0, 9) == 0) send($urandom_range(0, 22), 1'b0, 1'b0);
      fw.delete();
      for (int i = 0; i < n; i++)
        fw.push_back(($urandom_range(0, 9) == 0) ? $urandom_range(23, 31) : $urandom_range(0, 22));
      run_frame($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
